// File: rtl/alarm_clock_ctrl.sv
// Mode sequencer and alarm controller for the digital alarm clock: issues
// single-cycle counter step commands, handles set-mode timeout and alarm ringing.
module alarm_clock_ctrl #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SET_TIMEOUT = 30,
    parameter int unsigned CW          = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       alarm_arm,
    input  logic [4:0] time_hr,
    input  logic [5:0] time_min,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    output logic       chain_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       amin_en,
    output logic       ahr_en,
    output logic       step_up,
    output logic [2:0] mode,
    output logic       blink,
    output logic       alarm_ring
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4
    } mode_t;

    localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(SET_TIMEOUT - 1);

    mode_t         state;
    mode_t         next_mode;
    logic [CW-1:0] ring_cnt;
    logic [CW-1:0] to_cnt;
    logic          match;
    logic          match_q;
    logic          any_btn;
    logic          step_req;

    always_comb begin
        match    = alarm_arm && (state == RUN) && (time_hr == alarm_hr) && (time_min == alarm_min);
        any_btn  = btn_mode || btn_up || btn_down;
        step_req = btn_up ^ btn_down;
        case (state)
            RUN:      next_mode = SET_HR;
            SET_HR:   next_mode = SET_MIN;
            SET_MIN:  next_mode = SET_AHR;
            SET_AHR:  next_mode = SET_AMIN;
            default:  next_mode = RUN;
        endcase
    end

    assign mode = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            chain_en   <= 1'b1;
            min_en     <= 1'b0;
            hr_en      <= 1'b0;
            amin_en    <= 1'b0;
            ahr_en     <= 1'b0;
            step_up    <= 1'b1;
            blink      <= 1'b0;
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
            to_cnt     <= '0;
            match_q    <= 1'b0;
        end else begin
            min_en  <= 1'b0;
            hr_en   <= 1'b0;
            amin_en <= 1'b0;
            ahr_en  <= 1'b0;
            match_q <= match;

            if (alarm_ring) begin
                if (any_btn || !alarm_arm) begin
                    alarm_ring <= 1'b0;
                    ring_cnt   <= '0;
                end else if (sec_tick) begin
                    if (ring_cnt == RING_LAST) begin
                        alarm_ring <= 1'b0;
                        ring_cnt   <= '0;
                    end else begin
                        ring_cnt <= ring_cnt + CW'(1);
                    end
                end
            end else if (match && !match_q) begin
                alarm_ring <= 1'b1;
                ring_cnt   <= '0;
            end

            // While ringing every button is swallowed by the stop above.
            if (!alarm_ring) begin
                if (btn_mode) begin
                    state    <= next_mode;
                    chain_en <= (next_mode == RUN);
                    blink    <= (next_mode != RUN);
                    to_cnt   <= '0;
                end else if (state != RUN) begin
                    if (sec_tick && !btn_up && !btn_down && to_cnt == TO_LAST) begin
                        state    <= RUN;
                        chain_en <= 1'b1;
                        blink    <= 1'b0;
                        to_cnt   <= '0;
                    end else begin
                        if (btn_up || btn_down)
                            to_cnt <= '0;
                        else if (sec_tick)
                            to_cnt <= to_cnt + CW'(1);
                        if (sec_tick)
                            blink <= ~blink;
                        if (step_req) begin
                            step_up <= btn_up;
                            case (state)
                                SET_HR:   hr_en   <= 1'b1;
                                SET_MIN:  min_en  <= 1'b1;
                                SET_AHR:  ahr_en  <= 1'b1;
                                SET_AMIN: amin_en <= 1'b1;
                                default:  ;
                            endcase
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed bench for alarm_clock_ctrl: mode sequencing, manual steps,
// set-mode timeout, alarm ring start/stop and asynchronous reset.
module tb_alarm_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick, btn_mode, btn_up, btn_down, alarm_arm;
    logic [4:0] time_hr, alarm_hr;
    logic [5:0] time_min, alarm_min;
    logic       chain_en, min_en, hr_en, amin_en, ahr_en, step_up, blink, alarm_ring;
    logic [2:0] mode;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    alarm_clock_ctrl #(.RING_SECS(60), .SET_TIMEOUT(30), .CW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .alarm_arm  (alarm_arm),
        .time_hr    (time_hr),
        .time_min   (time_min),
        .alarm_hr   (alarm_hr),
        .alarm_min  (alarm_min),
        .chain_en   (chain_en),
        .min_en     (min_en),
        .hr_en      (hr_en),
        .amin_en    (amin_en),
        .ahr_en     (ahr_en),
        .step_up    (step_up),
        .mode       (mode),
        .blink      (blink),
        .alarm_ring (alarm_ring)
    );

    always #5 clk = ~clk;

    // {min_en, hr_en, amin_en, ahr_en}
    wire [3:0] ens = {min_en, hr_en, amin_en, ahr_en};

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
    endtask

    task automatic tick();
        sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        sec_tick = 0; btn_mode = 0; btn_up = 0; btn_down = 0; alarm_arm = 0;
        time_hr = 5'd7; time_min = 6'd29; alarm_hr = 5'd7; alarm_min = 6'd30;
        #13;
        check("rst_mode", mode, 0);
        check("rst_chain", chain_en, 1);
        check("rst_ens", ens, 0);
        check("rst_step_up", step_up, 1);
        check("rst_blink", blink, 0);
        check("rst_ring", alarm_ring, 0);
        rst = 1'b1;
        cyc();

        // Mode walk
        for (int unsigned i = 1; i <= 5; i++) begin
            press_mode();
            check("walk_mode", mode, i % 5);
            check("walk_chain", chain_en, (i % 5 == 0) ? 1 : 0);
            check("walk_blink", blink, (i % 5 == 0) ? 0 : 1);
        end

        // Manual steps in SET_MIN
        press_mode(); press_mode();
        check("setmin_mode", mode, 2);
        btn_up = 1'b1; cyc(); btn_up = 1'b0;
        check("up_ens", ens, 4'b1000);
        check("up_dir", step_up, 1);
        cyc();
        check("up_ens_off", ens, 0);
        btn_down = 1'b1; cyc(); btn_down = 1'b0;
        check("down_ens", ens, 4'b1000);
        check("down_dir", step_up, 0);
        cyc();
        check("down_ens_off", ens, 0);
        btn_up = 1'b1; btn_down = 1'b1; cyc(); btn_up = 1'b0; btn_down = 1'b0;
        check("both_ens", ens, 0);
        check("both_mode", mode, 2);
        tick();
        check("blink_toggle", blink, 0);
        tick();
        check("blink_toggle2", blink, 1);

        // Timeout in SET_AHR
        press_mode();
        check("setahr_mode", mode, 3);
        ticks(29);
        check("to_29", mode, 3);
        tick();
        check("to_30", mode, 0);
        check("to_chain", chain_en, 1);
        check("to_blink", blink, 0);

        // Timeout restart by btn_up at tick 20
        press_mode(); press_mode(); press_mode();
        check("setahr2_mode", mode, 3);
        ticks(19);
        sec_tick = 1'b1; btn_up = 1'b1; cyc(); sec_tick = 1'b0; btn_up = 1'b0;
        check("restart_ahr_en", ens, 4'b0001);
        ticks(29);
        check("restart_29", mode, 3);
        tick();
        check("restart_30", mode, 0);

        // Alarm ring and auto-stop
        alarm_arm = 1'b1;
        cyc(); cyc();
        check("pre_match_ring", alarm_ring, 0);
        time_min = 6'd30; cyc();
        check("ring_start", alarm_ring, 1);
        ticks(59);
        check("ring_59", alarm_ring, 1);
        tick();
        check("ring_60", alarm_ring, 0);
        ticks(5); cyc();
        check("no_rering", alarm_ring, 0);

        // Stop by button: consumed, mode unchanged
        time_min = 6'd31; cyc();
        time_min = 6'd30; cyc();
        check("ring2_start", alarm_ring, 1);
        press_mode();
        check("btn_stop_ring", alarm_ring, 0);
        check("btn_stop_mode", mode, 0);

        // Stop by disarm
        time_min = 6'd31; cyc();
        time_min = 6'd30; cyc();
        check("ring3_start", alarm_ring, 1);
        alarm_arm = 1'b0; cyc();
        check("disarm_stop", alarm_ring, 0);
        alarm_arm = 1'b1;

        // Match edge coinciding with btn_mode: ringing in SET_HR, then async reset
        time_min = 6'd31; cyc();
        time_min = 6'd30; btn_mode = 1'b1; cyc(); btn_mode = 1'b0;
        check("ring_sethr_ring", alarm_ring, 1);
        check("ring_sethr_mode", mode, 1);
        #2 rst = 1'b0;
        #1;
        check("async_mode", mode, 0);
        check("async_ring", alarm_ring, 0);
        check("async_chain", chain_en, 1);
        check("async_blink", blink, 0);
        check("async_step_up", step_up, 1);
        #4 rst = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_clock_ctrl.md
Name: alarm_clock_ctrl

Overview:
Mode and alarm controller for the digital alarm clock. It sequences the time counters (seconds/minutes/hours) and the alarm-setpoint counters through run and set modes by issuing single-cycle en/updown commands. It also compares current time against the alarm setpoint and drives the alarm output. It sits between the debounced button front-end and the counter datapath, and feeds mode/blink information to the display mux.

Parameters:
RING_SECS, 60, maximum alarm ring duration in seconds before auto-stop
SET_TIMEOUT, 30, idle seconds in any set mode before auto-return to RUN
CW, 6, width of the internal second counters used for ring and timeout (must hold max(RING_SECS, SET_TIMEOUT))

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted at 0)
sec_tick  in  1  one-cycle pulse, once per second
btn_mode  in  1  debounced one-cycle pulse, advance mode
btn_up  in  1  debounced one-cycle pulse, increment selected field
btn_down  in  1  debounced one-cycle pulse, decrement selected field
alarm_arm  in  1  level switch; 1 = alarm armed
time_hr  in  5  current hour (0-23) from hour counter
time_min  in  6  current minute (0-59) from minute counter
alarm_hr  in  5  alarm hour setpoint
alarm_min  in  6  alarm minute setpoint
chain_en  out  1  enables the normal seconds→minutes→hours carry chain
min_en  out  1  one-cycle manual step for the minute counter
hr_en  out  1  one-cycle manual step for the hour counter
amin_en  out  1  one-cycle step for the alarm-minute counter
ahr_en  out  1  one-cycle step for the alarm-hour counter
step_up  out  1  updown for all manual steps; 1 = up, 0 = down
mode  out  3  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_AHR, 4=SET_AMIN
blink  out  1  display blink for the selected field
alarm_ring  out  1  buzzer drive

Behaviour:
- Reset (rst=0, async): mode=RUN, chain_en=1, all *_en=0, step_up=1, blink=0, alarm_ring=0, ring/timeout counters=0, match_q=0.
- All outputs are registered. Command outputs appear the cycle after the causing input pulse.
- FSM: RUN -btn_mode-> SET_HR -> SET_MIN -> SET_AHR -> SET_AMIN -btn_mode-> RUN.
- chain_en=1 only in RUN. In set modes the time counters freeze and manual steps do not carry (a minute wrap does not touch hours).
- Set modes: btn_up pulses the selected field's *_en for exactly one cycle with step_up=1. btn_down does the same with step_up=0. If btn_up and btn_down are high in the same cycle, both are ignored. Both are ignored in RUN.
- Priority within a cycle: btn_mode over btn_up/btn_down. A mode change and a step never occur in the same cycle.
- Timeout: counts sec_tick in set modes. Cleared by any button pulse and on every mode entry. On reaching SET_TIMEOUT, mode goes to RUN on the next cycle.
- blink: 0 in RUN. In set modes it toggles on each sec_tick and is forced to 1 on set-mode entry.
- Alarm match: match = alarm_arm & (mode==RUN) & (time_hr==alarm_hr) & (time_min==alarm_min). match_q is the registered copy of match.
- Ring start: alarm_ring rises the cycle after match & ~match_q, i.e. on the rising edge of match only.
- Ring stop (alarm_ring=0 next cycle) on any of:
  - any button pulse — the pulse is consumed, so btn_mode does not change mode;
  - alarm_arm=0;
  - RING_SECS sec_ticks counted since ring start.
- After a stop, the alarm does not re-ring within the same matching minute because there is no new match edge.
- Entering a set mode is impossible while ringing, since the button is consumed by the stop.
- Reset mid-ring or mid-set returns to the reset state immediately.

Test Plan:
- Reset then btn_mode ×5 → mode sequence 1,2,3,4,0. chain_en=0 in modes 1-4 and 1 in mode 0.
- mode=SET_MIN, btn_up → min_en=1 for exactly one cycle with step_up=1. btn_down → min_en one cycle with step_up=0. btn_up & btn_down together → no *_en asserted.
- mode=SET_AHR, 30 sec_ticks with no buttons → mode=0 the cycle after the 30th tick. A btn_up at tick 20 restarts the count, so exit happens 30 ticks after that press.
- alarm_arm=1, alarm 07:30, time steps 07:29→07:30 in RUN → alarm_ring=1 one cycle after the match. It stays high 60 sec_ticks, then drops, and does not re-ring while time stays 07:30.
- Ringing, btn_mode pulse → alarm_ring=0 next cycle and mode stays 0. Ringing, alarm_arm→0 → alarm_ring=0 next cycle.
- rst=0 asserted mid-ring in SET_HR and between clock edges → all outputs at reset values immediately, without waiting for clk.
